// File: rtl/wrr_pop_arbiter.sv
// ============================================================================
// Module   : wrr_pop_arbiter
// Purpose  : Weighted-round-robin pop/push arbiter between NCH input FIFOs
//            and NCH output FIFOs. Fixed-priority selection (ch0 first)
//            within a round. Per-channel credit counters are bounded by
//            WEIGHTS. The round refresh does not insert an idle cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrr_pop_arbiter #(
  parameter int                NCH        = 4,
  parameter int                WW         = 3,
  parameter logic [NCH*WW-1:0] WEIGHTS    = {3'd1, 3'd2, 3'd3, 3'd4},
  parameter int                PUSH_DELAY = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NCH-1:0]         empty_fifo,
  input  logic [NCH-1:0]         almost_full_fifo,
  output logic [NCH-1:0]         pop,
  output logic [NCH-1:0]         push,
  output logic                   grant_valid,
  output logic [$clog2(NCH)-1:0] grant_idx,
  output logic                   round_done
);

  localparam int IW = $clog2(NCH);

  logic [NCH-1:0][WW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]         elig, cand, req, pop_d;
  logic                   stall, refresh, found;
  logic [IW-1:0]          sel_idx;
  logic                   grant_valid_q, round_done_q;
  logic [IW-1:0]          grant_idx_q;

  // Eligibility, bubble-free refresh detection, lowest-index selection and
  // next credit values.
  always_comb begin
    stall   = reset || !enable || (|almost_full_fifo);
    elig    = '0;
    cand    = '0;
    found   = 1'b0;
    sel_idx = '0;
    pop_d   = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      elig[i] = !empty_fifo[i] && (cnt_q[i] < WEIGHTS[i*WW +: WW]);
      cand[i] = !empty_fifo[i] && (WEIGHTS[i*WW +: WW] != '0);
    end
    // With no credit left anywhere, the refresh grant is chosen as if
    // every counter were already zero, so the round restarts this cycle.
    refresh = !stall && (elig == '0) && (cand != '0);
    req     = (elig != '0) ? elig : cand;
    for (int i = 0; i < NCH; i++) begin
      if (req[i] && !found) begin
        found   = 1'b1;
        sel_idx = IW'(i);
      end
    end
    if (!stall && found) begin
      pop_d[sel_idx] = 1'b1;
      if (refresh) begin
        cnt_d          = '0;
        cnt_d[sel_idx] = WW'(1);
      end else begin
        cnt_d[sel_idx] = cnt_q[sel_idx] + WW'(1);
      end
    end
  end

  // Credit counters and registered grant status.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      round_done_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      grant_valid_q <= |pop_d;
      round_done_q  <= refresh;
      if (|pop_d) begin
        grant_idx_q <= sel_idx;
      end
    end
  end

  assign pop         = pop_d;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign round_done  = round_done_q;

  if (PUSH_DELAY == 0) begin : g_push_comb
    assign push = pop_d;
  end else begin : g_push_reg
    logic [NCH-1:0] push_q;
    // Push follows pop one cycle later; it is not re-gated by a later stall.
    always_ff @(posedge clk) begin
      if (reset) begin
        push_q <= '0;
      end else begin
        push_q <= pop_d;
      end
    end
    assign push = push_q;
  end

endmodule

`default_nettype wire
